// File: rtl/mio_pkg.sv
// Shared definitions for the CPU memory/IO bus responder: FSM states, IO page
// register offsets and the default IO page base.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } mio_state_e;

  localparam logic [11:0] OFS_LED      = 12'h000;
  localparam logic [11:0] OFS_TMR_CNT  = 12'h004;
  localparam logic [11:0] OFS_TMR_LOAD = 12'h008;
  localparam logic [11:0] OFS_STATUS   = 12'h00C;

  localparam logic [31:0] MIO_IO_BASE_DEFAULT = 32'hF000_0000;

endpackage

// File: rtl/mio_timer.sv
// Interval timer: counts down from load, reloads on expiry and latches a
// pending interrupt that software clears by write-1 to STATUS.
module mio_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_we,
  input  logic [31:0] load_val,
  input  logic        clr,
  output logic [31:0] cnt,
  output logic [31:0] load,
  output logic        irq
);

  logic expire;

  // A load write pre-empts the countdown, so it can never expire on that edge.
  assign expire = !load_we && (load != '0) && (cnt <= 32'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      load <= '0;
      irq  <= 1'b0;
    end else begin
      if (load_we) begin
        load <= load_val;
        cnt  <= load_val;
      end else if (load != '0) begin
        cnt <= (cnt <= 32'd1) ? load : cnt - 32'd1;
      end
      if (expire)   irq <= 1'b1;
      else if (clr) irq <= 1'b0;
    end
  end

endmodule

// File: rtl/mio_bus_responder.sv
// Target side of the CPU memory/IO bus: word RAM with wait states plus an IO
// page holding the LED register and interval timer.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] IO_BASE     = MIO_IO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mio_req,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mio_ready,
  output logic [15:0] led,
  output logic        INT
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  mio_state_e  state;
  logic [3:0]  wcnt;
  logic [31:2] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_we;
  logic [31:0] mem [MEM_WORDS];

  logic [31:2]   cur_addr;
  logic          cur_we;
  logic          cur_io;
  logic [11:0]   cur_ofs;
  logic [AW-1:0] cur_idx;
  logic [31:0]   rd_val;
  logic          commit;
  logic          tmr_load_we;
  logic          tmr_clr;
  logic [31:0]   tmr_cnt;
  logic [31:0]   tmr_load;
  logic          tmr_irq;
  logic          unused_addr;

  assign unused_addr = ^addr[1:0];

  // In IDLE the decode looks at the live bus so rdata can be registered on the
  // same edge that accepts an IO request; afterwards it uses the latched copy.
  always_comb begin
    cur_addr = (state == IDLE) ? addr[31:2] : lat_addr;
    cur_we   = (state == IDLE) ? mem_w : lat_we;
    cur_io   = (cur_addr[31:12] == IO_BASE[31:12]);
    cur_ofs  = {cur_addr[11:2], 2'b00};
    cur_idx  = cur_addr[AW+1:2];
    rd_val   = '0;
    if (cur_io) begin
      case (cur_ofs)
        OFS_LED:      rd_val = {16'b0, led};
        OFS_TMR_CNT:  rd_val = tmr_cnt;
        OFS_TMR_LOAD: rd_val = tmr_load;
        OFS_STATUS:   rd_val = {31'b0, tmr_irq};
        default:      rd_val = '0;
      endcase
    end else begin
      rd_val = mem[cur_idx];
    end
  end

  assign commit      = (state == RESP) && lat_we;
  assign tmr_load_we = commit && cur_io && (cur_ofs == OFS_TMR_LOAD);
  assign tmr_clr     = commit && cur_io && (cur_ofs == OFS_STATUS) && lat_wdata[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      rdata     <= '0;
      mio_ready <= 1'b0;
      led       <= '0;
    end else begin
      mio_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mio_req) begin
            lat_addr  <= addr[31:2];
            lat_wdata <= wdata;
            lat_we    <= mem_w;
            if (cur_io || (WAIT_CYCLES == 0)) begin
              state     <= RESP;
              mio_ready <= 1'b1;
              rdata     <= cur_we ? '0 : rd_val;
            end else begin
              state <= WAIT;
              wcnt  <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) begin
            state     <= RESP;
            mio_ready <= 1'b1;
            rdata     <= cur_we ? '0 : rd_val;
          end
        end
        RESP: begin
          state <= IDLE;
          if (commit && cur_io && (cur_ofs == OFS_LED)) led <= lat_wdata[15:0];
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit && !cur_io) mem[cur_idx] <= lat_wdata;
  end

  mio_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_we  (tmr_load_we),
    .load_val (lat_wdata),
    .clr      (tmr_clr),
    .cnt      (tmr_cnt),
    .load     (tmr_load),
    .irq      (tmr_irq)
  );

  assign INT = tmr_irq;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed bench for mio_bus_responder: RAM wait states, aliasing, reset abort,
// IO LED register and the interval timer with its clear/expiry race.
module tb_mio_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mio_req = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        mio_ready;
  logic [15:0] led;
  logic        INT;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mio_bus_responder #(
    .MEM_WORDS   (1024),
    .WAIT_CYCLES (2),
    .IO_BASE     (32'hF000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mio_req   (mio_req),
    .mem_w     (mem_w),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .mio_ready (mio_ready),
    .led       (led),
    .INT       (INT)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus transaction; returns one edge after ready, with the FSM back in IDLE.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_rd, input string tag);
    int lat;
    @(negedge clk);
    mio_req = 1'b1; mem_w = we; addr = a; wdata = d;
    @(posedge clk); #1;
    lat = 1;
    while (!mio_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " rdata"}, rdata, exp_rd);
    mio_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int pulses;

    repeat (2) @(posedge clk);
    #1;
    check("reset rdata", rdata, 32'h0);
    check("reset ready", {31'b0, mio_ready}, 32'h0);
    check("reset led", {16'b0, led}, 32'h0);
    check("reset INT", {31'b0, INT}, 32'h0);
    @(negedge clk) reset = 1'b0;

    access(1'b1, 32'h0000_0010, 32'h0000_5555, 3, 32'h0, "preload 0x10");

    // Store aborted by reset asserted in cycle 1.
    @(negedge clk);
    mio_req = 1'b1; mem_w = 1'b1; addr = 32'h0000_0010; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    pulses = mio_ready ? 1 : 0;
    reset = 1'b1; mio_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (mio_ready) pulses++; end
    @(negedge clk) reset = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (mio_ready) pulses++; end
    check("abort ready pulses", 32'(pulses), 32'h0);
    access(1'b0, 32'h0000_0010, 32'h0, 3, 32'h0000_5555, "abort readback");

    access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 3, 32'h0, "ram store");
    access(1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, "ram load");
    access(1'b1, 32'h0000_1000, 32'h0000_00A5, 3, 32'h0, "alias store");
    access(1'b0, 32'h0000_0000, 32'h0, 3, 32'h0000_00A5, "alias load");

    access(1'b1, 32'hF000_0000, 32'hFFFF_00C3, 1, 32'h0, "led store");
    check("led value", {16'b0, led}, 32'h0000_00C3);
    access(1'b0, 32'hF000_0000, 32'h0, 1, 32'h0000_00C3, "led load");
    check("rdata hold", rdata, 32'h0000_00C3);
    check("ready idle", {31'b0, mio_ready}, 32'h0);
    access(1'b0, 32'hF000_0010, 32'h0, 1, 32'h0, "unmapped io");
    access(1'b1, 32'hF000_0004, 32'h0000_0077, 1, 32'h0, "tmr_cnt store");
    access(1'b0, 32'hF000_0004, 32'h0, 1, 32'h0, "tmr_cnt ro");

    // Timer: load 5 commits on the edge before this point; expiry 5 edges later.
    access(1'b1, 32'hF000_0008, 32'h0000_0005, 1, 32'h0, "tmr_load store");
    repeat (4) begin @(posedge clk); #1; check("INT before expiry", {31'b0, INT}, 32'h0); end
    @(posedge clk); #1;
    check("INT first rise", {31'b0, INT}, 32'h1);

    access(1'b1, 32'hF000_000C, 32'h0000_0001, 1, 32'h0, "status clear");
    check("INT cleared", {31'b0, INT}, 32'h0);
    repeat (2) begin @(posedge clk); #1; check("INT after clear", {31'b0, INT}, 32'h0); end
    @(posedge clk); #1;
    check("INT second rise", {31'b0, INT}, 32'h1);

    // Clear commits on the same edge as the next expiry: set must win.
    repeat (3) @(posedge clk);
    #1;
    access(1'b1, 32'hF000_000C, 32'h0000_0001, 1, 32'h0, "race clear");
    check("INT after race", {31'b0, INT}, 32'h1);
    access(1'b0, 32'hF000_0008, 32'h0, 1, 32'h0000_0005, "tmr_load read");

    access(1'b1, 32'hF000_0008, 32'h0, 1, 32'h0, "timer stop");
    access(1'b0, 32'hF000_0004, 32'h0, 1, 32'h0, "tmr_cnt stopped a");
    repeat (7) @(posedge clk);
    access(1'b0, 32'hF000_0004, 32'h0, 1, 32'h0, "tmr_cnt stopped b");
    access(1'b0, 32'hF000_000C, 32'h0, 1, 32'h0000_0001, "status read");
    check("INT held", {31'b0, INT}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
